// File: rtl/router_fifo_if.sv
// rtl/router_fifo_if.sv - write/read strobe, flush and status bundle for router_fifo
interface router_fifo_if #(
    parameter int DATA_W = 8
);
    logic              write_enb;
    logic              lfd_state;
    logic [DATA_W-1:0] data_in;
    logic              read_enb;
    logic              soft_reset;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] data_out;

    modport master (
        output write_enb, lfd_state, data_in, read_enb, soft_reset,
        input  full, empty, data_out
    );

    modport slave (
        input  write_enb, lfd_state, data_in, read_enb, soft_reset,
        output full, empty, data_out
    );
endinterface

// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - packet FIFO with header-tagged entries; ROUTER_FIFO_TRISTATE_EN makes idle data_out high-Z
module router_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic          clock,
    input  logic          resetn,
    router_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W:0]   mem [DEPTH];
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic [6:0]        pkt_cnt;
    logic [DATA_W-1:0] data_q;
    logic              full;
    logic              empty;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W:0]   rd_word;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign wr_en   = bus.write_enb && !full;
    assign rd_en   = bus.read_enb && !empty;
    assign rd_word = mem[rptr[AW-1:0]];

    // Storage is never cleared; only the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (wr_en && !bus.soft_reset)
            mem[wptr[AW-1:0]] <= {bus.lfd_state, bus.data_in};
    end

`ifdef ROUTER_FIFO_TRISTATE_EN
    logic data_idle;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            data_idle <= 1'b1;
        else if (bus.soft_reset)
            data_idle <= 1'b1;
        else if (rd_en)
            data_idle <= 1'b0;
        else if (pkt_cnt == 7'd0 && !bus.read_enb)
            data_idle <= 1'b1;
    end

    assign bus.data_out = data_idle ? {DATA_W{1'bz}} : data_q;
`else
    assign bus.data_out = data_q;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wptr    <= '0;
            rptr    <= '0;
            pkt_cnt <= '0;
            data_q  <= '0;
        end else if (bus.soft_reset) begin
            wptr    <= '0;
            rptr    <= '0;
            pkt_cnt <= '0;
            data_q  <= '0;
        end else begin
            if (wr_en)
                wptr <= wptr + 1'b1;
            if (rd_en) begin
                rptr   <= rptr + 1'b1;
                data_q <= rd_word[DATA_W-1:0];
                // Header byte carries the payload length in bits [7:2]; +1 covers parity.
                if (rd_word[DATA_W])
                    pkt_cnt <= {1'b0, rd_word[7:2]} + 7'd1;
                else if (pkt_cnt != 7'd0)
                    pkt_cnt <= pkt_cnt - 7'd1;
            end else if (pkt_cnt == 7'd0 && !bus.read_enb) begin
                data_q <= '0;
            end
        end
    end

    assign bus.full  = full;
    assign bus.empty = empty;
endmodule

// File: doc/router_fifo.md
ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 Parameter DATA_W, default 8, byte width of the packet datapath.
REQ-002 Parameter DEPTH, default 16, number of storage entries; power of two, at least 4.
REQ-003 clock  input  1  single clock; all state changes on rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 write_enb  input  1  write strobe for this FIFO, from the router's write-enable decode.
REQ-006 lfd_state  input  1  marks the current write byte as a packet header.
REQ-007 data_in  input  DATA_W  write byte.
REQ-008 read_enb  input  1  read strobe from the destination port.
REQ-009 soft_reset  input  1  synchronous flush request from the router's read-timeout logic.
REQ-010 full  output  1  no free entry.
REQ-011 empty  output  1  no stored entry.
REQ-012 data_out  output  DATA_W  registered read byte.

Function
REQ-013 Storage SHALL be DEPTH entries of DATA_W+1 bits; the extra MSB stores lfd_state with the byte.
REQ-014 Read and write pointers SHALL be log2(DEPTH)+1 bits wide, with the MSB acting as wrap bit.
REQ-015 empty SHALL be 1 when the pointers are equal; full SHALL be 1 when the low bits are equal and the wrap bits differ; both are combinational from the pointers.
REQ-016 A write SHALL occur when write_enb=1 and full=0, storing {lfd_state,data_in} and incrementing wptr; a write while full SHALL be dropped, even if a read occurs in the same cycle.
REQ-017 A read SHALL occur when read_enb=1 and empty=0; data_out SHALL update on the same edge (1-cycle latency), and rptr SHALL increment.
REQ-018 A read while empty SHALL be ignored; pointers and data_out are unchanged.
REQ-019 Simultaneous read and write with 0<occupancy<DEPTH SHALL both take effect, and occupancy is unchanged.
REQ-020 A 7-bit packet counter SHALL load data[7:2]+1 (payload plus parity) when a header entry is read.
REQ-021 The counter SHALL decrement on each non-header read while nonzero, and SHALL saturate at 0.
REQ-022 When the counter is 0 and no read occurs, data_out SHALL take the idle value (REQ-029/030) on the next edge; otherwise data_out holds its value.
REQ-023 Pointer arithmetic SHALL wrap modulo 2*DEPTH with no special-case logic.

Reset
REQ-024 resetn=0 SHALL asynchronously clear wptr, rptr, and the counter, and set data_out to its idle value.
REQ-025 During and immediately after reset, empty=1 and full=0.
REQ-026 Memory contents SHALL NOT be cleared; correctness depends only on the pointers.
REQ-027 soft_reset=1 SHALL, on the clock edge, clear the pointers and counter and set data_out to idle. It takes priority over write_enb and read_enb in the same cycle, and mid-packet data is discarded.
REQ-028 Release of resetn SHALL NOT require any cycle of recovery; the first edge after release may write.

Configuration
REQ-029 When ROUTER_FIFO_TRISTATE_EN is defined, the idle value of data_out SHALL be all-Z.
REQ-030 When ROUTER_FIFO_TRISTATE_EN is undefined, the idle value of data_out SHALL be all-zero; all other behaviour is identical.

Verification
REQ-031 Reset, then header 0x0C with lfd=1, then 3 payload bytes and a parity byte, then 5 reads: data_out=0x0C,p0,p1,p2,par with 1-cycle latency; the counter loads 4 and reaches 0; on the next idle cycle data_out=idle.
REQ-032 16 writes with no reads: full=1 after the 16th; a 17th write with data 0xAA is dropped; 16 reads return the original order; empty=1 after the last read.
REQ-033 With 8 entries stored, simultaneous read and write for 20 cycles: occupancy stays 8, pointers wrap, and data order is preserved.
REQ-034 Read strobe while empty: data_out, empty, and the pointers are unchanged.
REQ-035 Soft_reset asserted mid-packet together with write_enb=1: next cycle empty=1, full=0, data_out=idle, and the written byte is absent.
REQ-036 resetn asserted low between clock edges while 5 entries are stored: empty=1 immediately, without waiting for a clock edge; run the bench under both macro settings.
